// File: rtl/vga_draw.sv
// vga_draw: 640x480@60Hz VGA timing plus snake-game pixel renderer.
//   Draws a 40x30 grid of 16x16 cells: white border, red food at (30,15),
//   and a 4-cell green snake in row 15 that advances once per frame after
//   trigger has been seen.
// Ports:
//   clk       in   25 MHz pixel clock, rising edge
//   reset     in   asynchronous, active-high
//   trigger   in   starts snake motion (sticky)
//   red_o     out  red pixel
//   grn_o     out  green pixel
//   blu_o     out  blue pixel
//   h_sync_o  out  horizontal sync, active low
//   v_sync_o  out  vertical sync, active low
module vga_draw #(
   parameter int H_VIS  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_VIS  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33
) (
   input  logic clk,
   input  logic reset,
   input  logic trigger,
   output logic red_o,
   output logic grn_o,
   output logic blu_o,
   output logic h_sync_o,
   output logic v_sync_o
);

   localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_VEND  = 10'(H_VIS);
   localparam logic [9:0] V_VEND  = 10'(V_VIS);
   localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC - 1);

   logic [9:0] hc, vc;
   logic [5:0] head;
   logic       running;

   // Counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hc <= '0;
         vc <= '0;
      end else if (hc == H_LAST) begin
         hc <= '0;
         vc <= (vc == V_LAST) ? 10'd0 : vc + 10'd1;
      end else begin
         hc <= hc + 10'd1;
      end
   end

   // Snake motion happens at the first blanking clock, so every visible
   // frame is drawn with a single head position.
   logic update;
   assign update = (hc == 10'd0) && (vc == V_VEND);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         running <= 1'b0;
         head    <= 6'd10;
      end else begin
         if (trigger) running <= 1'b1;
         // running is the pre-edge value: a trigger on the update clock
         // does not move the snake that frame.
         if (update && running) head <= (head == 6'd38) ? 6'd1 : head + 6'd1;
      end
   end

   // Pixel decode
   logic [5:0] cx;
   logic [4:0] cy;
   logic       visible, border, food, snake;
   logic [6:0] col;

   assign cx      = hc[9:4];
   assign cy      = vc[8:4];
   assign visible = (hc < H_VEND) && (vc < V_VEND);
   assign border  = (cx == 6'd0) || (cx == 6'd39) || (cy == 5'd0) || (cy == 5'd29);
   assign food    = (cx == 6'd30) && (cy == 5'd15);

   // Body cell k sits at head-k, wrapped into the interior 1..38.
   // head+38-k is always >= 36, so one conditional subtract wraps it.
   always_comb begin
      snake = 1'b0;
      col   = '0;
      for (int k = 0; k < 4; k++) begin
         col = {1'b0, head} + 7'd38 - 7'(k);
         if (col > 7'd38) col = col - 7'd38;
         if ((cy == 5'd15) && (col[5:0] == cx)) snake = 1'b1;
      end
   end

   // Output stage: sync and colour registered together so they stay aligned.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         red_o    <= 1'b0;
         grn_o    <= 1'b0;
         blu_o    <= 1'b0;
         h_sync_o <= 1'b1;
         v_sync_o <= 1'b1;
      end else begin
         red_o    <= visible & (border | (food & ~snake));
         grn_o    <= visible & (border | snake);
         blu_o    <= visible & border;
         h_sync_o <= ~((hc >= HS_BEG) && (hc <= HS_END));
         v_sync_o <= ~((vc >= VS_BEG) && (vc <= VS_END));
      end
   end

endmodule

// File: tb/tb_vga_draw.sv
// Self-checking bench for vga_draw. A bench-side model of the counters and
// snake predicts each pixel; the prediction is queued when the clock edge is
// driven and compared one clock later when the registered output appears.
// Counter jumps (force/release) skip the long stretches of a frame.
module tb_vga_draw;

   logic clk = 1'b0;
   logic reset, trigger;
   logic red_o, grn_o, blu_o, h_sync_o, v_sync_o;

   vga_draw dut (
      .clk(clk), .reset(reset), .trigger(trigger),
      .red_o(red_o), .grn_o(grn_o), .blu_o(blu_o),
      .h_sync_o(h_sync_o), .v_sync_o(v_sync_o)
   );

   always #20 clk = ~clk;

   typedef struct {
      int         h;
      int         v;
      logic [4:0] px;   // {r,g,b,hs,vs}
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          mh, mv, mhead;
   bit          mrun;
   logic [39:0] gmask, rmask;
   int          hs_low, vs_low, col_on;

   function automatic logic [4:0] model_px(input int h, input int v, input int hd);
      bit vis, brd, snk, fd, hs, vs;
      int cx, cy, d;
      vis = (h < 640) && (v < 480);
      cx  = h / 16;
      cy  = v / 16;
      brd = (cx == 0) || (cx == 39) || (cy == 0) || (cy == 29);
      d   = hd - cx;
      if (d < 0) d += 38;
      snk = (cy == 15) && (cx >= 1) && (cx <= 38) && (d <= 3);
      fd  = (cx == 30) && (cy == 15);
      hs  = !((h >= 656) && (h <= 751));
      vs  = !((v >= 490) && (v <= 491));
      return {vis && (brd || (fd && !snk)), vis && (brd || snk), vis && brd, hs, vs};
   endfunction

   task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One pixel clock: queue the prediction for the current model counters,
   // advance the model, clock the DUT, then compare at the falling edge.
   task automatic tick();
      exp_t e;
      e.h  = mh;
      e.v  = mv;
      e.px = model_px(mh, mv, mhead);
      sb.push_back(e);
      if (mh == 0 && mv == 480 && mrun) mhead = (mhead == 38) ? 1 : mhead + 1;
      if (trigger) mrun = 1'b1;
      if (mh == 799) begin
         mh = 0;
         mv = (mv == 524) ? 0 : mv + 1;
      end else begin
         mh++;
      end
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("pixel h=%0d v=%0d", e.h, e.v),
            40'({red_o, grn_o, blu_o, h_sync_o, v_sync_o}), 40'(e.px));
      if (e.v == 240 && e.h < 640) begin
         if (grn_o && !red_o) gmask[e.h / 16] = 1'b1;
         if (red_o && !grn_o) rmask[e.h / 16] = 1'b1;
      end
      if (!h_sync_o) hs_low++;
      if (!v_sync_o) vs_low++;
      if (red_o || grn_o || blu_o) col_on++;
   endtask

   task automatic jump(input int h, input int v);
      force dut.hc = 10'(h);
      force dut.vc = 10'(v);
      #1;
      release dut.hc;
      release dut.vc;
      mh = h;
      mv = v;
   endtask

   task automatic row_check(input string tag, input logic [39:0] exp_g);
      gmask = '0;
      rmask = '0;
      jump(790, 239);
      repeat (830) tick();
      check({tag, " green cells"}, gmask, exp_g);
      check({tag, " red cells"}, rmask, 40'h00_4000_0000);
   endtask

   // Walk the counters through one update point (hc=0, vc=480).
   task automatic do_update();
      jump(798, 479);
      repeat (3) tick();
   endtask

   task automatic model_reset();
      mh    = 0;
      mv    = 0;
      mhead = 10;
      mrun  = 1'b0;
      sb.delete();
   endtask

   initial begin
      reset   = 1'b1;
      trigger = 1'b0;
      model_reset();

      // Reset state
      @(posedge clk);
      #1 check("reset outputs", 40'({red_o, grn_o, blu_o, h_sync_o, v_sync_o}), 40'h03);
      @(negedge clk);   // 40 ns
      check("reset outputs at release", 40'({red_o, grn_o, blu_o, h_sync_o, v_sync_o}), 40'h03);
      reset = 1'b0;

      // Two free-running lines from the top: border, hsync width and period
      hs_low = 0;
      repeat (1600) tick();
      check("hsync low clocks in 2 lines", 40'(hs_low), 40'd192);

      // Vertical blanking: vsync width and no colour
      jump(0, 489);
      vs_low = 0;
      col_on = 0;
      repeat (3200) tick();
      check("vsync low clocks", 40'(vs_low), 40'd1600);
      check("colour during vblank", 40'(col_on), 40'd0);

      // No trigger: update point passes without motion
      do_update();
      row_check("idle head10", 40'h00_0000_0780);

      // Trigger on the update clock itself: no move that frame
      jump(798, 479);
      repeat (2) tick();
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      row_check("trigger at update", 40'h00_0000_0780);

      // Next update moves by one
      do_update();
      row_check("head11", 40'h00_0000_0F00);

      // Advance to head 38, then wrap to 1
      repeat (27) do_update();
      row_check("head38", 40'h78_0000_0000);
      do_update();
      row_check("head1 wrap", 40'h70_0000_0002);

      // Reset mid-line while a white border pixel is being shown
      jump(0, 100);
      repeat (2) tick();
      reset = 1'b1;
      #1 check("async reset outputs", 40'({red_o, grn_o, blu_o, h_sync_o, v_sync_o}), 40'h03);
      repeat (3) begin
         @(negedge clk);
         check("reset held outputs", 40'({red_o, grn_o, blu_o, h_sync_o, v_sync_o}), 40'h03);
      end
      reset = 1'b0;
      model_reset();
      repeat (40) tick();
      // running was cleared: an update point does not move head from 10
      do_update();
      row_check("after reset", 40'h00_0000_0780);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
